// File: rtl/ram_dump_reader_pkg.sv
// Shared definitions for the RAM dump reader: default geometry, FSM state
// encoding and word/byte helpers used by the top and the word serializer.
package ram_dump_reader_pkg;

    localparam int NB_DATA_DEF    = 16;
    localparam int NB_ADDR_DEF    = 10;
    localparam int NB_BYTE_DEF    = 8;
    localparam int BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic int bytes_per_word(input int nb_data, input int nb_byte);
        return nb_data / nb_byte;
    endfunction

    function automatic bit width_is_multiple(input int nb_data, input int nb_byte);
        return (nb_data % nb_byte) == 0;
    endfunction

endpackage

// File: rtl/ram_dump_reader_word_serializer.sv
// Holds one RAM word and hands it out MSB-first, one byte per valid/ready
// handshake; flags the handshake that consumes the final byte of the word.
module ram_dump_reader_word_serializer
    import ram_dump_reader_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_BYTE = NB_BYTE_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_load_data,
    input  logic               i_tx_ready,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    output logic               o_last_byte,
    output logic               o_word_done
);

    localparam int BPW   = bytes_per_word(NB_DATA, NB_BYTE);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [NB_DATA-1:0] shift_q;
    logic [IDX_W-1:0]   idx_q;
    logic               valid_q;
    logic               last_s;
    logic               handshake_s;

    assign last_s      = (idx_q == IDX_W'(BPW - 1));
    assign handshake_s = valid_q & i_tx_ready;

    // Load a fresh word, or advance one byte per accepted handshake.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shift_q <= {NB_DATA{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            valid_q <= 1'b0;
        end else if (i_load) begin
            shift_q <= i_load_data;
            idx_q   <= {IDX_W{1'b0}};
            valid_q <= 1'b1;
        end else if (handshake_s) begin
            if (last_s) begin
                valid_q <= 1'b0;
            end else begin
                shift_q <= shift_q << NB_BYTE;
                idx_q   <= idx_q + IDX_W'(1);
            end
        end else begin
            shift_q <= shift_q;
            idx_q   <= idx_q;
            valid_q <= valid_q;
        end
    end

    assign o_tx_data   = shift_q[NB_DATA-1 -: NB_BYTE];
    assign o_tx_valid  = valid_q;
    assign o_last_byte = last_s;
    assign o_word_done = handshake_s & last_s;

endmodule

// File: rtl/ram_dump_reader.sv
// Walks a RAM address window on a start command and streams each word out
// as bytes, MSB first, over a valid/ready interface to the UART transmitter.
module ram_dump_reader
    import ram_dump_reader_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF,
    parameter int NB_BYTE = NB_BYTE_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic [NB_ADDR-1:0] i_base_address,
    input  logic [NB_ADDR:0]   i_length,
    output logic               o_read_enable,
    output logic [NB_ADDR-1:0] o_read_address,
    input  logic [NB_DATA-1:0] i_read_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam int LEN_W = NB_ADDR + 1;

    if (!width_is_multiple(NB_DATA, NB_BYTE)) begin : g_bad_width
        $error("ram_dump_reader: NB_DATA must be a multiple of NB_BYTE");
    end

    state_e             state_q;
    logic [NB_ADDR-1:0] addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic               rd_en_q;
    logic               busy_q;
    logic               done_q;

    logic               word_done_s;
    logic               last_byte_s;
    logic               more_words_s;

    // Counter never exceeds len-1, so cnt+1 always fits in LEN_W bits.
    assign more_words_s = ((cnt_q + LEN_W'(1)) < len_q);

    // Dump sequencing: window latch, address/word counting, status outputs.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= {NB_ADDR{1'b0}};
            len_q   <= {LEN_W{1'b0}};
            cnt_q   <= {LEN_W{1'b0}};
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (i_start && (i_length != {LEN_W{1'b0}})) begin
                        addr_q  <= i_base_address;
                        len_q   <= i_length;
                        cnt_q   <= {LEN_W{1'b0}};
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end else if (i_start) begin
                        busy_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    rd_en_q <= 1'b0;
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    if (word_done_s && more_words_s) begin
                        addr_q  <= addr_q + NB_ADDR'(1);
                        cnt_q   <= cnt_q + LEN_W'(1);
                        rd_en_q <= 1'b1;
                        state_q <= ST_LOAD;
                    end else if (word_done_s) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_SEND;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    rd_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // rd_en_q is high exactly during LOAD, so it doubles as the capture strobe.
    ram_dump_reader_word_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_word_serializer (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .i_load      (rd_en_q),
        .i_load_data (i_read_data),
        .i_tx_ready  (i_tx_ready),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .o_last_byte (last_byte_s),
        .o_word_done (word_done_s)
    );

    assign o_read_enable  = rd_en_q;
    assign o_read_address = addr_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;

endmodule

// File: tb/tb_ram_dump_reader.sv
// Directed bench for ram_dump_reader with a combinational RAM model.
module tb_ram_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  base;
    logic [10:0] length;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [15:0] rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    logic [7:0] got[$];
    logic [9:0] addrs[$];
    int done_cnt, first_valid, done_cyc, stab_err;

    always #5 clk = ~clk;

    assign rd_data = mem[rd_addr];

    ram_dump_reader dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_start        (start),
        .i_base_address (base),
        .i_length       (length),
        .o_read_enable  (rd_en),
        .o_read_address (rd_addr),
        .i_read_data    (rd_data),
        .o_tx_data      (tx_data),
        .o_tx_valid     (tx_valid),
        .i_tx_ready     (tx_ready),
        .o_busy         (busy),
        .o_done         (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] exp[$]);
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) check($sformatf("%s_b%0d", tag, i), {24'd0, got[i]}, {24'd0, exp[i]});
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {10'd0, rd_en, rd_addr, tx_data, tx_valid, busy, done}, 32'd0);
    endtask

    // Issue a start, then watch the interface one negedge per cycle.
    task automatic run_dump(input logic [9:0] b, input logic [10:0] len, input logic [31:0] pat,
                            input int inj_start, input int rst_after, input int budget);
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       rdy;
        logic       did_rst;
        int         stop_at;
        got.delete();
        addrs.delete();
        done_cnt    = 0;
        first_valid = -1;
        done_cyc    = -1;
        stab_err    = 0;
        prev_stall  = 1'b0;
        prev_data   = 8'd0;
        did_rst     = 1'b0;
        stop_at     = budget;
        @(negedge clk);
        start    = 1'b1;
        base     = b;
        length   = len;
        tx_ready = pat[0];
        for (int cyc = 1; cyc <= stop_at; cyc++) begin
            @(negedge clk);
            start = (cyc == inj_start);
            if (cyc == inj_start) begin
                base   = 10'd0;
                length = 11'd1;
            end
            rdy      = pat[cyc % 32];
            tx_ready = rdy;
            if (prev_stall && (!tx_valid || tx_data !== prev_data)) stab_err++;
            if (rd_en) addrs.push_back(rd_addr);
            if (tx_valid && first_valid < 0) first_valid = cyc;
            if (tx_valid && rdy) got.push_back(tx_data);
            prev_stall = tx_valid && !rdy;
            prev_data  = tx_data;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    stop_at  = cyc + 3;
                end
            end
            if (!did_rst && rst_after >= 0 && got.size() == rst_after) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                check_outputs_zero("midreset_outputs");
                @(negedge clk);
                rst_n      = 1'b1;
                did_rst    = 1'b1;
                prev_stall = 1'b0;
                stop_at    = cyc + 6;
            end
        end
        start    = 1'b0;
        tx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] exp[$];
        int         mism;
        for (int i = 0; i < 1024; i++) mem[i] = 16'((i * 40503 + 12345) & 32'hFFFF);
        mem[0]     = 16'hC0DE;
        mem[5]     = 16'hA53C;
        mem[10]    = 16'h1122;
        mem[11]    = 16'h3344;
        mem[12]    = 16'h5566;
        mem[20]    = 16'h0102;
        mem[21]    = 16'h0304;
        mem[22]    = 16'h0506;
        mem[23]    = 16'h0708;
        mem[40]    = 16'hDEAD;
        mem[41]    = 16'hF00D;
        mem[42]    = 16'h1234;
        mem[50]    = 16'h9876;
        mem[10'h3FF] = 16'hBEEF;

        rst_n    = 1'b0;
        start    = 1'b0;
        base     = 10'd0;
        length   = 11'd0;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_outputs");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_valid", {31'd0, tx_valid}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Single word, ready held high.
        run_dump(10'd5, 11'd1, 32'hFFFF_FFFF, -1, -1, 40);
        exp = '{8'hA5, 8'h3C};
        check_bytes("single", exp);
        check("single_latency", first_valid, 32'd2);
        check("single_done_cyc", done_cyc, 32'd4);
        check("single_done_cnt", done_cnt, 32'd1);
        check("single_addr_cnt", addrs.size(), 32'd1);
        check("single_addr", {22'd0, addrs[0]}, 32'd5);
        check("single_busy_after", {31'd0, busy}, 32'd0);

        // Three words with irregular backpressure.
        run_dump(10'd10, 11'd3, 32'b1011_0010_1100_1110_0101_1001_0011_0110, -1, -1, 200);
        exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        check_bytes("multi", exp);
        check("multi_stable", stab_err, 32'd0);
        check("multi_done_cnt", done_cnt, 32'd1);
        check("multi_addr_cnt", addrs.size(), 32'd3);
        check("multi_addr_last", {22'd0, addrs[2]}, 32'd12);

        // Window wraps from the top address to zero.
        run_dump(10'h3FF, 11'd2, 32'hFFFF_FFFF, -1, -1, 40);
        exp = '{8'hBE, 8'hEF, 8'hC0, 8'hDE};
        check_bytes("wrap", exp);
        check("wrap_addr0", {22'd0, addrs[0]}, 32'h3FF);
        check("wrap_addr1", {22'd0, addrs[1]}, 32'h000);
        check("wrap_done_cnt", done_cnt, 32'd1);

        // Zero length: immediate done, nothing read or sent.
        run_dump(10'd7, 11'd0, 32'hFFFF_FFFF, -1, -1, 20);
        check("zero_done_cyc", done_cyc, 32'd1);
        check("zero_bytes", got.size(), 32'd0);
        check("zero_reads", addrs.size(), 32'd0);
        check("zero_valid_seen", first_valid, 32'hFFFF_FFFF);

        // Start pulse while busy must be ignored.
        run_dump(10'd20, 11'd4, 32'hFFFF_FFFF, 5, -1, 60);
        exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        check_bytes("busystart", exp);
        check("busystart_done_cnt", done_cnt, 32'd1);
        check("busystart_addr_cnt", addrs.size(), 32'd4);
        check("busystart_addr_last", {22'd0, addrs[3]}, 32'd23);

        // Reset after the third byte aborts silently.
        run_dump(10'd40, 11'd3, 32'hFFFF_FFFF, -1, 3, 60);
        exp = '{8'hDE, 8'hAD, 8'hF0};
        check_bytes("abort", exp);
        check("abort_done_cnt", done_cnt, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, tx_valid}, 32'd0);

        run_dump(10'd50, 11'd1, 32'hFFFF_FFFF, -1, -1, 40);
        exp = '{8'h98, 8'h76};
        check_bytes("after_abort", exp);
        check("after_abort_done_cnt", done_cnt, 32'd1);

        // Full-memory dump from the middle, every address once.
        run_dump(10'h200, 11'd1024, 32'hFFFF_FFFF, -1, -1, 3300);
        check("full_count", got.size(), 32'd2048);
        check("full_reads", addrs.size(), 32'd1024);
        mism = 0;
        for (int i = 0; i < 1024; i++) begin
            if (2 * i + 1 < got.size()) begin
                if (got[2*i]   !== mem[(32'h200 + i) % 1024][15:8]) mism++;
                if (got[2*i+1] !== mem[(32'h200 + i) % 1024][7:0])  mism++;
            end
        end
        check("full_data", mism, 32'd0);
        check("full_last_addr", {22'd0, addrs[1023]}, 32'h1FF);
        check("full_done_cnt", done_cnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_dump_reader.md
Name: ram_dump_reader

Overview:
Sequential reader on the read port of the instruction/data RAM (low-latency, combinational-read memory). On a start command it walks a contiguous address window and emits each word as a stream of bytes, MSB first, on a valid/ready byte interface to the UART transmitter. It is the readback/debug path that complements the program-loader writer on the RAM write port.

Parameters:
NB_DATA, 16, RAM word width; must be an integer multiple of NB_BYTE
NB_ADDR, 10, RAM address width; window wraps modulo 2**NB_ADDR
NB_BYTE, 8, output byte width

Ports:
i_clock  in  1  system clock, all state on rising edge
i_reset_n  in  1  asynchronous, active-low reset
i_start  in  1  one-cycle request to begin a dump; ignored while o_busy=1
i_base_address  in  NB_ADDR  first word address, sampled when start is accepted
i_length  in  NB_ADDR+1  number of words to dump, sampled on accepted start; 0 allowed
o_read_enable  out  1  high in LOAD state
o_read_address  out  NB_ADDR  registered RAM read address
i_read_data  in  NB_DATA  RAM combinational read data
o_tx_data  out  NB_BYTE  byte to transmitter
o_tx_valid  out  1  byte valid
i_tx_ready  in  1  transmitter accepts byte when valid&ready
o_busy  out  1  high in any state other than IDLE
o_done  out  1  one-cycle pulse at end of dump

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; address, word counter, byte index, shift register cleared. Reset mid-dump aborts silently: no o_done, o_tx_valid drops immediately.
- States: IDLE, LOAD, SEND, DONE.
- IDLE: i_start=1 & i_length!=0 -> latch base into o_read_address, latch length, word counter=0 -> LOAD. i_start=1 & i_length=0 -> DONE (no bytes sent).
- LOAD (exactly 1 cycle): o_read_enable=1; i_read_data captured into shift register at end of cycle; byte index=0 -> SEND. Data value is forwarded as-is (including whatever the RAM returns at address 0).
- SEND: o_tx_valid=1, o_tx_data = shift register[NB_DATA-1 -: NB_BYTE]. Data and valid held stable until handshake (valid&ready). On handshake:
  - byte index < BYTES_PER_WORD-1: shift left by NB_BYTE, index+1, stay SEND (next byte valid next cycle, back-to-back allowed with ready held high).
  - last byte & word counter < length-1: o_read_address+1 (wraps 2**NB_ADDR-1 -> 0), counter+1 -> LOAD.
  - last byte & last word -> DONE.
- DONE: o_done=1 for one cycle, o_tx_valid=0 -> IDLE. o_busy=1 in DONE, 0 in IDLE.
- Latency: start accepted at edge N -> LOAD during cycle N+1 -> first o_tx_valid in cycle N+2. Steady state with ready=1: BYTES_PER_WORD+1 cycles per word (one LOAD bubble).
- i_start while busy: ignored, no effect on latched parameters.
- i_length = 2**NB_ADDR: full memory dump, every address once, wrap honoured.
- i_tx_ready asserted without valid: no effect.

Decomposition:
- Shared package: BYTES_PER_WORD = NB_DATA/NB_BYTE, state encoding localparams (IDLE=2'd0, LOAD=2'd1, SEND=2'd2, DONE=2'd3), elaboration check NB_DATA % NB_BYTE == 0.
- One natural sub-module: word_serializer (shift register + byte index + valid/ready handshake, with load strobe and last-byte flag); FSM and address/word counters stay in the top.

Test Plan:
- Reset then idle: i_reset_n=0 mid-frame -> all outputs 0 same cycle; after release no o_tx_valid, o_busy=0.
- Single word: RAM[5]=16'hA53C, base=5, length=1, ready=1 -> bytes 8'hA5 then 8'h3C on consecutive cycles starting 2 cycles after start, o_done pulse 1 cycle after last handshake, o_read_address=5.
- Multi-word with backpressure: RAM[10..12]=16'h1122,16'h3344,16'h5566, length=3, ready toggled randomly -> byte stream 11 22 33 44 55 66 exactly once each, o_tx_data stable while valid&!ready.
- Wrap-around: base=10'h3FF, length=2, RAM[3FF]=16'hBEEF, RAM[1]... RAM[0] as returned by memory -> addresses 3FF then 000, bytes BE EF followed by memory's address-0 value.
- Zero length and start-while-busy: length=0 -> o_done 1 cycle after start, no valid; during a 4-word dump pulse i_start with base=0,length=1 -> ignored, exactly 8 bytes emitted, single o_done.
- Reset mid-dump: assert i_reset_n=0 after 3rd byte -> no o_done, next start from IDLE dumps correctly from new base.
